// File: rtl/fp_pkg.sv
// fp_pkg
// Shared constants and types for the floating-point alignment path.
//   MANT_W    : mantissa width including the hidden bit
//   GRS_W     : guard/round/sticky bits appended below the mantissa
//   EXT_W     : extended mantissa width {M, G, R, S}
//   SAT_SHIFT : shift amount at and beyond which every mantissa bit is lost
//   CNT_W     : width of the remaining-shift counter (holds 0..26)
//   aligner_state_t : control states of grs_aligner
package fp_pkg;

  localparam int MANT_W = 24;
  localparam int GRS_W  = 3;
  localparam int EXT_W  = 27;
  localparam int CNT_W  = 5;

  localparam logic [7:0] SAT_SHIFT = 8'd27;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } aligner_state_t;

endpackage

// File: rtl/grs_shift_step.sv
// grs_shift_step
// One combinational right-shift step of the extended mantissa with sticky merge.
// Every bit shifted out below position 0 is ORed into the new bit 0, so the
// LSB always represents "anything nonzero was discarded so far".
// Ports:
//   din  : extended mantissa before the step
//   amt  : shift amount for this step (0..4); 0 passes din through unchanged
//   dout : shifted mantissa with sticky folded into bit 0
module grs_shift_step
  import fp_pkg::*;
(
  input  logic [EXT_W-1:0] din,
  input  logic [2:0]       amt,
  output logic [EXT_W-1:0] dout
);

  logic [EXT_W-1:0] lost_mask;
  logic             lost_any;

  // The mask selects exactly the amt low bits that fall off the end; the old
  // bit 0 is among them, so previously accumulated sticky is carried along.
  always_comb begin
    lost_mask = (EXT_W'(1) << amt) - EXT_W'(1);
    lost_any  = |(din & lost_mask);
    dout      = din >> amt;
    dout[0]   = dout[0] | lost_any;
  end

endmodule

// File: rtl/grs_aligner.sv
// grs_aligner
// Multi-cycle right aligner for the smaller addend of an FP add. The operand
// {mant_in, 3'b000} is shifted right by shamt, STEP bits per cycle, with all
// discarded bits collapsed into the sticky LSB. Shifts of 27 or more skip the
// shifter entirely since only the sticky can survive.
// Parameters:
//   STEP      : bits shifted per SHIFT cycle (1, 2 or 4)
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   in_valid  : operand offered
//   in_ready  : operand can be accepted (IDLE only)
//   mant_in   : mantissa, hidden bit at [23]
//   shamt     : unsigned right-shift amount
//   out_valid : result available (DONE)
//   out_ready : consumer takes the result
//   ext_mant  : {M[23:0], G, R, S}
//   shift_sat : shamt was 27 or more
module grs_aligner
  import fp_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] mant_in,
  input  logic [7:0]        shamt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EXT_W-1:0]  ext_mant,
  output logic              shift_sat
);

  localparam logic [CNT_W-1:0] STEP_CNT = CNT_W'(STEP);
  localparam logic [2:0]       STEP_AMT = 3'(STEP);

  aligner_state_t   state, state_next;
  logic [EXT_W-1:0] ext_q, ext_next;
  logic             sat_q, sat_next;
  logic [CNT_W-1:0] rem_q, rem_next;
  logic [2:0]       step_amt;
  logic [EXT_W-1:0] step_out;

  // Last step may be shorter than STEP so the total is exactly shamt.
  always_comb begin
    step_amt = (rem_q < STEP_CNT) ? rem_q[2:0] : STEP_AMT;
  end

  grs_shift_step u_step (
    .din  (ext_q),
    .amt  (step_amt),
    .dout (step_out)
  );

  // State and datapath registers; reset clears everything so a reset during
  // SHIFT or DONE drops the operation without a trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ext_q <= '0;
      sat_q <= 1'b0;
      rem_q <= '0;
    end else begin
      state <= state_next;
      ext_q <= ext_next;
      sat_q <= sat_next;
      rem_q <= rem_next;
    end
  end

  // Next-state and datapath update. Inputs are only looked at in IDLE, so
  // later changes on mant_in/shamt cannot disturb an operation in flight.
  always_comb begin
    state_next = state;
    ext_next   = ext_q;
    sat_next   = sat_q;
    rem_next   = rem_q;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          if (shamt >= SAT_SHIFT) begin
            ext_next   = {{(EXT_W-1){1'b0}}, |mant_in};
            sat_next   = 1'b1;
            rem_next   = '0;
            state_next = DONE;
          end else begin
            ext_next   = {mant_in, {GRS_W{1'b0}}};
            sat_next   = 1'b0;
            rem_next   = shamt[CNT_W-1:0];
            state_next = (shamt == 8'd0) ? DONE : SHIFT;
          end
        end
      end
      SHIFT: begin
        ext_next = step_out;
        rem_next = rem_q - {2'b00, step_amt};
        if (rem_next == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake flags follow the state directly; the result registers are
  // frozen in DONE because only SHIFT and IDLE write them.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    ext_mant  = ext_q;
    shift_sat = sat_q;
  end

endmodule

// File: tb/tb_grs_aligner.sv
// tb_grs_aligner
// Drives three aligners (STEP = 1, 2, 4) in lockstep from shared inputs and
// compares each against an arithmetic reference for value, saturation flag
// and accept-to-valid latency.
module tb_grs_aligner;
  import fp_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              out_ready;
  logic [MANT_W-1:0] mant_in;
  logic [7:0]        shamt;

  logic              in_ready  [3];
  logic              out_valid [3];
  logic [EXT_W-1:0]  ext_mant  [3];
  logic              shift_sat [3];

  int steps [3] = '{1, 2, 4};
  int got_lat [3];
  int vec_count  = 0;
  int miss_count = 0;

  always #5 clk = ~clk;

  grs_aligner #(.STEP(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .mant_in(mant_in), .shamt(shamt), .out_valid(out_valid[0]),
    .out_ready(out_ready), .ext_mant(ext_mant[0]), .shift_sat(shift_sat[0])
  );
  grs_aligner #(.STEP(2)) dut_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .mant_in(mant_in), .shamt(shamt), .out_valid(out_valid[1]),
    .out_ready(out_ready), .ext_mant(ext_mant[1]), .shift_sat(shift_sat[1])
  );
  grs_aligner #(.STEP(4)) dut_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
    .mant_in(mant_in), .shamt(shamt), .out_valid(out_valid[2]),
    .out_ready(out_ready), .ext_mant(ext_mant[2]), .shift_sat(shift_sat[2])
  );

  typedef struct {
    logic [23:0] mant;
    logic [7:0]  sh;
    logic [26:0] ext;
    logic        sat;
    int          lat1;
    int          lat2;
    int          lat4;
  } vec_t;

  vec_t tbl [8];

  // Reference: exact division by 2^shamt on the zero-extended operand, with
  // the remainder collapsed into bit 0; latency is one accept cycle plus the
  // number of STEP-sized chunks needed to cover shamt.
  function automatic void refModel(input logic [23:0] m, input int sh, input int step,
                                   output logic [26:0] e, output logic s, output int lat);
    longint unsigned full, kept, lost;
    if (sh >= 27) begin
      e   = {26'b0, (m != 24'd0)};
      s   = 1'b1;
      lat = 1;
    end else begin
      full = longint'(m) * 8;
      kept = full >> sh;
      lost = full - (kept << sh);
      e    = kept[26:0] | {26'b0, (lost != 0)};
      s    = 1'b0;
      lat  = 1 + (sh + step - 1) / step;
    end
  endfunction

  task automatic compareVal(input string what, input logic [31:0] got, input logic [31:0] want);
    vec_count++;
    if (got !== want) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", what, got, want);
    end
  endtask

  // Offer one operand, then scramble the inputs and record, per instance, how
  // many edges (counting the accept edge) pass until out_valid is seen.
  task automatic applyStimulus(input logic [23:0] m, input logic [7:0] sh);
    bit all_seen;
    for (int i = 0; i < 3; i++) begin
      compareVal($sformatf("ready_before_accept/step%0d", steps[i]), 32'(in_ready[i]), 32'd1);
    end
    in_valid = 1'b1;
    mant_in  = m;
    shamt    = sh;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mant_in  = 24'($urandom);
    shamt    = 8'($urandom);
    for (int i = 0; i < 3; i++) got_lat[i] = 0;
    for (int c = 1; c <= 40; c++) begin
      all_seen = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (got_lat[i] == 0 && out_valid[i]) got_lat[i] = c;
        if (got_lat[i] == 0) all_seen = 1'b0;
      end
      if (all_seen) break;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input logic [26:0] e, input logic s,
                             input int l1, input int l2, input int l4);
    int want_lat [3];
    want_lat = '{l1, l2, l4};
    for (int i = 0; i < 3; i++) begin
      compareVal($sformatf("%s/step%0d/ext_mant", name, steps[i]), 32'(ext_mant[i]), 32'(e));
      compareVal($sformatf("%s/step%0d/shift_sat", name, steps[i]), 32'(shift_sat[i]), 32'(s));
      compareVal($sformatf("%s/step%0d/latency", name, steps[i]), 32'(got_lat[i]), 32'(want_lat[i]));
    end
  endtask

  task automatic releaseResult(input string name);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      compareVal($sformatf("%s/step%0d/idle_ready", name, steps[i]), 32'(in_ready[i]), 32'd1);
      compareVal($sformatf("%s/step%0d/idle_valid", name, steps[i]), 32'(out_valid[i]), 32'd0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [23:0] m;
    logic [7:0]  sh;
    logic [26:0] e_ref;
    logic        s_ref;
    int          l_ref [3];
    logic [26:0] held [3];

    tbl[0] = '{24'h800000, 8'd0,   27'h4000000, 1'b0, 1,  1,  1};
    tbl[1] = '{24'h800001, 8'd5,   27'h0200001, 1'b0, 6,  4,  3};
    tbl[2] = '{24'h800000, 8'd26,  27'h0000001, 1'b0, 27, 14, 8};
    tbl[3] = '{24'h800000, 8'd27,  27'h0000001, 1'b1, 1,  1,  1};
    tbl[4] = '{24'h000001, 8'd200, 27'h0000001, 1'b1, 1,  1,  1};
    tbl[5] = '{24'h000000, 8'd13,  27'h0000000, 1'b0, 14, 8,  5};
    tbl[6] = '{24'hFFFFFF, 8'd1,   27'h3FFFFFC, 1'b0, 2,  2,  2};
    tbl[7] = '{24'hABCDEF, 8'd3,   27'h0ABCDEF, 1'b0, 4,  3,  2};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    mant_in   = '0;
    shamt     = '0;
    #1;
    for (int i = 0; i < 3; i++) begin
      compareVal($sformatf("reset/step%0d/in_ready", steps[i]), 32'(in_ready[i]), 32'd1);
      compareVal($sformatf("reset/step%0d/out_valid", steps[i]), 32'(out_valid[i]), 32'd0);
      compareVal($sformatf("reset/step%0d/ext_mant", steps[i]), 32'(ext_mant[i]), 32'd0);
      compareVal($sformatf("reset/step%0d/shift_sat", steps[i]), 32'(shift_sat[i]), 32'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed table");
    for (int v = 0; v < 8; v++) begin
      applyStimulus(tbl[v].mant, tbl[v].sh);
      checkOutput($sformatf("tbl%0d", v), tbl[v].ext, tbl[v].sat, tbl[v].lat1, tbl[v].lat2, tbl[v].lat4);
      releaseResult($sformatf("tbl%0d", v));
    end

    $display("[TB] hold in DONE with back-pressure");
    applyStimulus(24'h800001, 8'd5);
    checkOutput("hold", 27'h0200001, 1'b0, 6, 4, 3);
    for (int i = 0; i < 3; i++) held[i] = ext_mant[i];
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      mant_in  = 24'($urandom);
      shamt    = 8'($urandom_range(0, 10));
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        compareVal($sformatf("hold%0d/step%0d/ext_mant", k, steps[i]), 32'(ext_mant[i]), 32'h0200001);
        compareVal($sformatf("hold%0d/step%0d/out_valid", k, steps[i]), 32'(out_valid[i]), 32'd1);
        compareVal($sformatf("hold%0d/step%0d/in_ready", k, steps[i]), 32'(in_ready[i]), 32'd0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      compareVal($sformatf("hold_release/step%0d/in_ready", steps[i]), 32'(in_ready[i]), 32'd1);
      compareVal($sformatf("hold_release/step%0d/out_valid", steps[i]), 32'(out_valid[i]), 32'd0);
    end

    $display("[TB] reset during SHIFT");
    in_valid = 1'b1;
    mant_in  = 24'hC0FFEE;
    shamt    = 8'd20;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      compareVal($sformatf("midreset/step%0d/out_valid", steps[i]), 32'(out_valid[i]), 32'd0);
      compareVal($sformatf("midreset/step%0d/ext_mant", steps[i]), 32'(ext_mant[i]), 32'd0);
      compareVal($sformatf("midreset/step%0d/in_ready", steps[i]), 32'(in_ready[i]), 32'd1);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      compareVal($sformatf("postreset/step%0d/in_ready", steps[i]), 32'(in_ready[i]), 32'd1);
      compareVal($sformatf("postreset/step%0d/out_valid", steps[i]), 32'(out_valid[i]), 32'd0);
    end
    applyStimulus(24'h800001, 8'd5);
    checkOutput("postreset_op", 27'h0200001, 1'b0, 6, 4, 3);
    releaseResult("postreset_op");

    $display("[TB] random operands against reference");
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0:       m = 24'h000000;
        1:       m = 24'($urandom_range(1, 255));
        default: m = 24'h800000 | 24'($urandom);
      endcase
      sh = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 30));
      for (int i = 0; i < 3; i++) refModel(m, int'(sh), steps[i], e_ref, s_ref, l_ref[i]);
      applyStimulus(m, sh);
      checkOutput($sformatf("rnd%0d_m%06h_s%0d", n, m, sh), e_ref, s_ref, l_ref[0], l_ref[1], l_ref[2]);
      releaseResult($sformatf("rnd%0d", n));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
